// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and default sizes for the product accumulator.
// Contents: state_t (IDLE/ACCUM/HOLD), P_W_DEF, N_DEF, ACC_W_DEF.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int P_W_DEF   = 8;
    localparam int N_DEF     = 4;
    localparam int ACC_W_DEF = 10;

endpackage

// File: rtl/prod_accum_add.sv
// prod_accum_add: combinational acc + zero-extended p_in with carry out.
// Ports: acc, p_in in; sum, carry out. PROD_ACCUM_SAT_EN clamps sum on carry.
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [P_W-1:0]   p_in,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, p_in};
    assign carry = full[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
    // Addends are unsigned, so once clamped at the maximum every
    // further add either carries again or adds zero: the clamp holds.
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums N products per frame, presents sum/ovf on a valid/ready port.
// Ports: clk, rst_n, clr, in_valid/in_ready/p_in, out_valid/out_ready,
// acc_out, ovf, beat_cnt. Option macro: PROD_ACCUM_SAT_EN (saturating sum).
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   p_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              sticky_q, sticky_d;
    logic              valid_q, valid_d;
    logic [ACC_W-1:0]  sum;
    logic              carry;

    prod_accum_add #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (acc_q),
        .p_in  (p_in),
        .sum   (sum),
        .carry (carry)
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = valid_q;
    assign acc_out   = res_q;
    assign ovf       = ovf_q;
    assign beat_cnt  = cnt_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        valid_d  = valid_q;
        if (clr) begin
            // Abort drops any same-cycle beat; last result stays visible.
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST) begin
                            res_d    = sum;
                            ovf_d    = sticky_q | carry;
                            valid_d  = 1'b1;
                            acc_d    = '0;
                            cnt_d    = '0;
                            sticky_d = 1'b0;
                            state_d  = HOLD;
                        end else begin
                            acc_d    = sum;
                            cnt_d    = cnt_q + 1'b1;
                            sticky_d = sticky_q | carry;
                            state_d  = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
        end
    end

endmodule
